fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 9-bit pipelined CPU, directly upstream of the program ROMs.
//  - Owns the PC and drives it to the ROM; the ROM returns the 9-bit instruction combinationally in the same cycle.
//  - Registers instruction + PC into the IF/ID pipeline register.
//  - Applies stall and branch redirect, and detects halt.

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/branch/writeback controls in, ROM address and
// IF/ID pipeline register out. The fetch stage uses the slave modport.
// Handshake: redirect_valid, stall and halt_commit are single-cycle level
// strobes sampled on the rising clock edge. There is no ready; the fetch
// stage acts on them in the cycle they are presented.
interface fetch_if;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halt_commit;
    logic [8:0]  instr_in;
    logic [7:0]  pc_out;
    logic [8:0]  ifid_instr;
    logic [7:0]  ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;
    logic [1:0]  dbg_state;

    modport slave (
        input  stall, redirect_valid, redirect_pc, halt_commit, instr_in,
        output pc_out, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count,
               dbg_state
    );

    modport master (
        output stall, redirect_valid, redirect_pc, halt_commit, instr_in,
        input  pc_out, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count,
               dbg_state
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 9-bit pipelined CPU.
// Owns the PC, registers the ROM instruction into IF/ID, applies stall and
// branch redirect, and parks the front end once a halt is fetched/retired.
// Optional macro IF_PERF_CNT_EN: enables the saturating delivered-instruction
// counter on fetch_count (otherwise fetch_count is constant zero).
module fetch_stage #(
    parameter logic [7:0] RESET_PC   = 8'd1,
    parameter logic [8:0] HALT_INSTR = 9'b110111000,
    parameter logic [8:0] NOP_INSTR  = 9'b000000000
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALTED    = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [8:0] r_ifid_instr;
    logic [7:0] r_ifid_pc;
    logic       r_ifid_valid;

    state_t     w_state_nxt;
    logic [7:0] w_pc_nxt;
    logic [8:0] w_ifid_instr_nxt;
    logic [7:0] w_ifid_pc_nxt;
    logic       w_ifid_valid_nxt;
    logic       w_load_valid;

    // State, PC and IF/ID registers; everything frozen by next-state logic when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= 8'd0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
        end
    end

    // Next-state: redirect beats stall in RUN; halt_commit beats redirect in HALT_PEND
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_valid_nxt = r_ifid_valid;
        w_load_valid     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt         = bus.redirect_pc;
                    w_ifid_instr_nxt = NOP_INSTR;
                    w_ifid_pc_nxt    = 8'd0;
                    w_ifid_valid_nxt = 1'b0;
                end else if (!bus.stall) begin
                    w_ifid_instr_nxt = bus.instr_in;
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_valid_nxt = 1'b1;
                    w_load_valid     = 1'b1;
                    if (bus.instr_in == HALT_INSTR) begin
                        // PC stays on the halt so nothing past it is fetched
                        w_state_nxt = ST_HALT_PEND;
                    end else begin
                        w_pc_nxt = r_pc + 8'd1;
                    end
                end
            end
            ST_HALT_PEND: begin
                if (bus.halt_commit) begin
                    w_state_nxt = ST_HALTED;
                end else if (bus.redirect_valid) begin
                    // The halt was on a mispredicted path; resume at the target
                    w_pc_nxt         = bus.redirect_pc;
                    w_ifid_instr_nxt = NOP_INSTR;
                    w_ifid_pc_nxt    = 8'd0;
                    w_ifid_valid_nxt = 1'b0;
                    w_state_nxt      = ST_RUN;
                end else if (!bus.stall) begin
                    w_ifid_instr_nxt = NOP_INSTR;
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_valid_nxt = 1'b0;
                end
            end
            default: begin
                // ST_HALTED: fully frozen until reset
            end
        endcase
    end

    assign bus.pc_out     = r_pc;
    assign bus.ifid_instr = r_ifid_instr;
    assign bus.ifid_pc    = r_ifid_pc;
    assign bus.ifid_valid = r_ifid_valid;
    assign bus.halted     = (r_state == ST_HALTED);
    assign bus.dbg_state  = r_state;

`ifdef IF_PERF_CNT_EN
    logic [15:0] r_fetch_count;

    // Count real instructions delivered into IF/ID, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 16'h0000;
        end else if (w_load_valid && (r_fetch_count != 16'hFFFF)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign bus.fetch_count = r_fetch_count;
`else
    logic w_unused_load;
    assign w_unused_load   = w_load_valid;
    assign bus.fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random
// stall/redirect/halt traffic, all compared each cycle to a reference model.
module tb_fetch_stage;

    localparam logic [8:0] HALT = 9'b110111000;
    localparam logic [8:0] NOP  = 9'b000000000;

    logic clk;
    logic rst_n;
    fetch_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Program ROM: combinational read at the fetch address
    logic [8:0] rom [256];
    assign bus.instr_in = rom[bus.pc_out];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 = fetching, 1 = halt seen awaiting retire, 2 = stopped
    int         m_mode;
    logic [7:0] m_pc;
    logic [8:0] m_instr;
    logic [7:0] m_ifpc;
    logic       m_valid;
    int         m_cnt;

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 8'd1;
        m_instr = NOP;
        m_ifpc  = 8'd0;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    // One rising edge worth of the fetch rules, using the inputs seen at the edge
    task automatic model_edge();
        logic [8:0] fetched;
        fetched = rom[m_pc];
        if (m_mode == 2) return;
        if (m_mode == 1 && bus.halt_commit) begin
            m_mode = 2;
        end else if (bus.redirect_valid) begin
            m_pc    = bus.redirect_pc;
            m_instr = NOP;
            m_ifpc  = 8'd0;
            m_valid = 1'b0;
            m_mode  = 0;
        end else if (bus.stall) begin
            // nothing moves
        end else if (m_mode == 1) begin
            m_instr = NOP;
            m_ifpc  = m_pc;
            m_valid = 1'b0;
        end else begin
            m_instr = fetched;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (fetched == HALT) m_mode = 1;
            else m_pc = 8'((int'(m_pc) + 1) % 256);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_cnt;
`ifdef IF_PERF_CNT_EN
        exp_cnt = 16'(m_cnt);
`else
        exp_cnt = 16'h0000;
`endif
        chk({tag, ".pc_out"},      16'(bus.pc_out),     16'(m_pc));
        chk({tag, ".ifid_instr"},  16'(bus.ifid_instr), 16'(m_instr));
        chk({tag, ".ifid_pc"},     16'(bus.ifid_pc),    16'(m_ifpc));
        chk({tag, ".ifid_valid"},  16'(bus.ifid_valid), 16'(m_valid));
        chk({tag, ".halted"},      16'(bus.halted),     16'(m_mode == 2));
        chk({tag, ".fetch_count"}, bus.fetch_count,     exp_cnt);
    endtask

    // Advance n edges, checking every output #1 after each edge
    task automatic cycles(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    task automatic idle_inputs();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'd0;
        bus.halt_commit    = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_rom(input int halt_pct);
        logic [8:0] v;
        for (int a = 0; a < 256; a++) begin
            v = 9'($urandom);
            if (v == HALT) v = 9'h001;
            if (int'($urandom_range(99, 0)) < halt_pct) v = HALT;
            rom[a] = v;
        end
    endtask

    initial begin
        idle_inputs();
        fill_rom(0);
        rom[18] = HALT;
        rom[30] = HALT;
        rst_n = 1'b0;
        #12;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from the reset PC
        cycles(2, "seq");
        // Stall for two cycles at pc=3
        bus.stall = 1'b1;
        cycles(2, "stall");
        bus.stall = 1'b0;
        cycles(7, "resume");
        // Redirect to 7 at pc=10 with stall also asserted
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'd7;
        cycles(1, "redir");
        idle_inputs();
        cycles(1, "redir_tgt");
        // Run into the halt at 18, bubble, retire, then ignore a redirect
        cycles(10, "to_halt");
        cycles(1, "halt_fetch");
        cycles(3, "halt_bubble");
        bus.halt_commit = 1'b1;
        cycles(1, "halt_commit");
        bus.halt_commit = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'd3;
        bus.stall = 1'b1;
        cycles(2, "halted_frozen");
        idle_inputs();

        // Halt on a wrong path, cancelled by a redirect before retiring
        do_reset("reset2");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'd30;
        cycles(1, "redir_to_halt");
        idle_inputs();
        cycles(2, "pend");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'd8;
        cycles(1, "pend_redir");
        idle_inputs();
        cycles(3, "after_cancel");

        // PC wrap 255 -> 0
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'd252;
        cycles(1, "redir_252");
        idle_inputs();
        cycles(6, "wrap");

        // Asynchronous reset while a halt is pending
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'd30;
        cycles(1, "redir_30");
        idle_inputs();
        cycles(2, "pend2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(5, "post_reset");

        // Random traffic with occasional halts in the program
        fill_rom(4);
        rom[1] = 9'h001;
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 59) do_reset("rnd_reset");
            bus.stall          = ($urandom_range(3, 0) == 0);
            bus.redirect_valid = ($urandom_range(9, 0) == 0);
            bus.redirect_pc    = 8'($urandom);
            bus.halt_commit    = ($urandom_range(4, 0) == 0);
            cycles(1, "rnd");
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
